// File: rtl/s_mem_responder.sv
// s_mem_responder: responder side of the start/finish memory handshake.
// Two initiators (A, B) are arbitrated round-robin and each granted request
// is sequenced onto a single-port synchronous RAM with fixed read latency.
module s_mem_responder #(
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned RAM_READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_start_readWrite_op,
  input  logic                  a_readWrite,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_data_out,
  output logic [DATA_WIDTH-1:0] a_data_in,
  output logic                  a_finish_readWrite_op,
  input  logic                  b_start_readWrite_op,
  input  logic                  b_readWrite,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_data_out,
  output logic [DATA_WIDTH-1:0] b_data_in,
  output logic                  b_finish_readWrite_op,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(RAM_READ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_b_q, grant_b_d;   // 1 = client B owns the transaction
  logic                  last_b_q, last_b_d;     // 1 = last grant went to B
  logic                  lat_wr_q, lat_wr_d;     // latched readWrite of the grant
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_data_in_q, a_data_in_d;
  logic [DATA_WIDTH-1:0] b_data_in_q, b_data_in_d;
  logic                  a_finish_q, a_finish_d;
  logic                  b_finish_q, b_finish_d;
  // ram_address/ram_data registers double as the request address/data latch
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  busy_q, busy_d;
  logic                  pick_b;
  logic                  gnt_start;

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_b_q     <= 1'b0;
      last_b_q      <= 1'b1;
      lat_wr_q      <= 1'b0;
      cnt_q         <= '0;
      a_data_in_q   <= '0;
      b_data_in_q   <= '0;
      a_finish_q    <= 1'b0;
      b_finish_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_b_q     <= grant_b_d;
      last_b_q      <= last_b_d;
      lat_wr_q      <= lat_wr_d;
      cnt_q         <= cnt_d;
      a_data_in_q   <= a_data_in_d;
      b_data_in_q   <= b_data_in_d;
      a_finish_q    <= a_finish_d;
      b_finish_q    <= b_finish_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
    end
  end

  // Arbitration, RAM sequencing and four-phase handshake next-state logic
  always_comb begin
    state_d       = state_q;
    grant_b_d     = grant_b_q;
    last_b_d      = last_b_q;
    lat_wr_d      = lat_wr_q;
    cnt_d         = cnt_q;
    a_data_in_d   = a_data_in_q;
    b_data_in_d   = b_data_in_q;
    a_finish_d    = a_finish_q;
    b_finish_d    = b_finish_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    pick_b        = 1'b0;
    gnt_start     = grant_b_q ? b_start_readWrite_op : a_start_readWrite_op;

    case (state_q)
      ST_IDLE: begin
        if (a_start_readWrite_op || b_start_readWrite_op) begin
          // On a tie the client that was not served last wins
          pick_b        = b_start_readWrite_op && (!a_start_readWrite_op || !last_b_q);
          grant_b_d     = pick_b;
          last_b_d      = pick_b;
          lat_wr_d      = pick_b ? b_readWrite : a_readWrite;
          ram_address_d = pick_b ? b_address : a_address;
          ram_data_d    = pick_b ? b_data_out : a_data_out;
          ram_wren_d    = pick_b ? b_readWrite : a_readWrite;
          state_d       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (lat_wr_q) begin
          if (grant_b_q) begin
            b_finish_d = 1'b1;
          end else begin
            a_finish_d = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_W'(RAM_READ_LATENCY);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          // ram_q is valid at the end of the last wait cycle
          if (grant_b_q) begin
            b_data_in_d = ram_q;
            b_finish_d  = 1'b1;
          end else begin
            a_data_in_d = ram_q;
            a_finish_d  = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (!gnt_start) begin
          a_finish_d = 1'b0;
          b_finish_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign a_data_in             = a_data_in_q;
  assign b_data_in             = b_data_in_q;
  assign a_finish_readWrite_op = a_finish_q;
  assign b_finish_readWrite_op = b_finish_q;
  assign ram_address           = ram_address_q;
  assign ram_data              = ram_data_q;
  assign ram_wren              = ram_wren_q;
  assign busy                  = busy_q;

endmodule
